// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter sharing one UART transmitter among NREQ sources
// Optional TX_TIMEOUT_EN: abort a transfer whose completion tick does not arrive within TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, ptr_nx, pick, owner_next;
  logic [IDW:0]    scan;
  logic            found;
  logic            timeout_hit;
  logic [NREQ-1:0] ack_nx, done_nx;
  logic            tx_start_nx, err_nx, busy_nx;
  logic [7:0]      tx_din_nx;
  logic [IDW-1:0]  grant_id_nx;

  // First set request at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ))
        scan = scan - (IDW+1)'(NREQ);
      if (!found && req[scan[IDW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IDW-1:0];
      end
    end
  end

  assign owner_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

`ifdef TX_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (state != WAIT)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (tx_done_tick || timeout_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs; a completion tick beats a simultaneous timeout.
  always_comb begin
    ack_nx      = '0;
    done_nx     = '0;
    tx_start_nx = 1'b0;
    err_nx      = 1'b0;
    busy_nx     = (state_nx != IDLE);
    tx_din_nx   = tx_din;
    grant_id_nx = grant_id;
    ptr_nx      = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_id_nx = pick;
          tx_din_nx   = req_data[{pick, 3'b000} +: 8];
          tx_start_nx = 1'b1;
          ack_nx      = NREQ'(1) << pick;
        end
      end
      WAIT: begin
        if (tx_done_tick) begin
          done_nx = NREQ'(1) << grant_id;
          ptr_nx  = owner_next;
        end else if (timeout_hit) begin
          err_nx = 1'b1;
          ptr_nx = owner_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      tx_din   <= '0;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      ack      <= ack_nx;
      done     <= done_nx;
      tx_start <= tx_start_nx;
      err      <= err_nx;
      busy     <= busy_nx;
      tx_din   <= tx_din_nx;
      grant_id <= grant_id_nx;
      ptr      <= ptr_nx;
    end
  end

endmodule
